imem_loader: RTL

Program loader for the instruction memory: accepts a byte stream over a valid/ready handshake, packs each group of four bytes little-endian into a 32-bit instruction word, and writes the words to consecutive addresses through port A of the `imem` block RAM (`ena`/`wea`/`addra`/`dina`). It sits beside the instruction fetch path and fills memory before the core runs. `busy` holds the core off the memory while a load is in progress.

---
 rtl/imem_pkg.sv | 13 +
 rtl/imem_loader.sv | 99 +++++++++
 2 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared instruction-memory geometry and loader state encoding
package imem_pkg;
    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DATA_W = 32;
    localparam int IMEM_BYTES  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_DONE
    } loader_state_t;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream little-endian into words and writes them to imem port A
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
);
    localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(1) << ADDR_W;
    localparam logic [1:0] LAST_IDX = 2'(IMEM_BYTES - 1);

    loader_state_t     state;
    logic [1:0]        idx;
    logic [DATA_W-9:0] hold;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   ww_next;

    assign ww_next = words_written + (ADDR_W+1)'(1);

    // The write address is the count of words already written, so no separate counter is kept.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state         <= ST_IDLE;
            idx           <= '0;
            hold          <= '0;
            len           <= '0;
            in_ready      <= 1'b0;
            ena           <= 1'b0;
            wea           <= 1'b0;
            addra         <= '0;
            dina          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= '0;
        end else begin
            ena  <= 1'b0;
            wea  <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start && !abort) begin
                    words_written <= '0;
                    busy          <= 1'b1;
                    idx           <= '0;
                    len           <= (load_len > CAP) ? CAP : load_len;
                    state         <= (load_len == '0) ? ST_DONE : ST_COLLECT;
                    done          <= (load_len == '0);
                    in_ready      <= (load_len != '0);
                end
                ST_COLLECT: if (in_valid && !abort) begin
                    idx <= idx + 2'd1;
                    if (idx == LAST_IDX) begin
                        dina     <= {in_data, hold};
                        addra    <= words_written[ADDR_W-1:0];
                        ena      <= 1'b1;
                        wea      <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= ST_WRITE;
                    end else begin
                        hold[8*idx +: 8] <= in_data;
                    end
                end
                ST_WRITE: begin
                    words_written <= ww_next;
                    state         <= (ww_next == len) ? ST_DONE : ST_COLLECT;
                    done          <= (ww_next == len);
                    in_ready      <= (ww_next != len);
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // Abort overrides the next state; a write already on the bus has finished this cycle.
            if (abort && state != ST_IDLE) begin
                state    <= ST_IDLE;
                in_ready <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b0;
                ena      <= 1'b0;
                wea      <= 1'b0;
            end
        end
    end
endmodule
